// File: rtl/step_sequencer.sv
// step_sequencer
//   Walks cnt through steps 1..NUM_STEPS after start. While a sequence is active:
//   stop aborts it, changed parks it in RESTART, and hold freezes it on a RUN step.
//   With REPEAT=1 the last step wraps back to 1.
//   Every completion gives a one-cycle done pulse and bumps a saturating run counter.
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    level; begins a sequence from IDLE
//   changed  level; forces RESTART while not IDLE
//   hold     level; freezes cnt on a RUN step
//   stop     level; aborts to IDLE from any non-IDLE state
//   cnt      current step: 0 = IDLE, 1..NUM_STEPS = RUN, all-ones = RESTART
//   busy     cnt != 0 (combinational)
//   done     one-cycle pulse, aligned with cnt showing the post-completion value
//   run_cnt  completions since reset, saturating
module step_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int CNT_W     = 3,
  parameter int REPEAT    = 0,
  parameter int RUN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             changed,
  input  logic             hold,
  input  logic             stop,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [RUN_W-1:0] run_cnt
);

  localparam logic [CNT_W-1:0] RESTART = '1;
  localparam logic [CNT_W-1:0] FIRST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_STEPS);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  // The state is carried entirely by cnt. This enum is only a decode of it.
  // ST_BAD covers codes between LAST and RESTART, which should never appear.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESTART, ST_BAD} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;
  logic [RUN_W-1:0] run_cnt_d, run_cnt_q;

  always_comb begin
    state = ST_IDLE;
    if (cnt_q == '0)          state = ST_IDLE;
    else if (cnt_q == RESTART) state = ST_RESTART;
    else if (cnt_q <= LAST)    state = ST_RUN;
    else                       state = ST_BAD;
  end

  always_comb begin
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    run_cnt_d = run_cnt_q;
    case (state)
      // In IDLE, only start has any effect.
      ST_IDLE: cnt_d = start ? FIRST : '0;
      // Recover silently from an illegal code, without a done pulse.
      ST_BAD:  cnt_d = '0;
      default: begin
        if (stop)                     cnt_d = '0;
        else if (changed)             cnt_d = RESTART;
        else if (state == ST_RESTART) cnt_d = FIRST;   // hold is ignored here
        else if (hold)                cnt_d = cnt_q;
        else if (cnt_q == LAST) begin
          cnt_d  = (REPEAT != 0) ? FIRST : '0;
          done_d = 1'b1;
          if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + 1'b1;
        end
        else                          cnt_d = cnt_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      done_q    <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign busy    = (cnt_q != '0);
  assign done    = done_q;
  assign run_cnt = run_cnt_q;

endmodule
